// File: rtl/dmem_block.sv
// rtl/dmem_block.sv - block-granular data memory responder for the data cache
// One 128-bit block read or write per request, completed after LATENCY cycles.
module dmem_block #(
  parameter int IDX_W   = 6,
  parameter int LATENCY = 5
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_address,
  input  logic [127:0] mem_WRITE_DATA,
  output logic [127:0] mem_READ_DATA,
  output logic         mem_busywait
);

  localparam int         DEPTH  = 1 << IDX_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               op_wr, op_wr_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [127:0]       wdata, wdata_nxt;
  logic [127:0]       rdata_nxt;
  logic               busy_nxt;
  logic               do_write;
  logic [127:0]       array [DEPTH];

  // Upper block-address bits alias onto the same blocks.
  logic unused_addr;
  assign unused_addr = ^mem_address[27:IDX_W];

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      op_wr         <= 1'b0;
      idx           <= '0;
      wdata         <= '0;
      mem_busywait  <= 1'b0;
      mem_READ_DATA <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      op_wr         <= op_wr_nxt;
      idx           <= idx_nxt;
      wdata         <= wdata_nxt;
      mem_busywait  <= busy_nxt;
      mem_READ_DATA <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_wr_nxt = op_wr;
    idx_nxt   = idx;
    wdata_nxt = wdata;
    rdata_nxt = mem_READ_DATA;
    busy_nxt  = mem_busywait;
    do_write  = 1'b0;
    case (state)
      IDLE: begin
        // A simultaneous read and write is treated as a write only.
        if (mem_write || mem_read) begin
          state_nxt = BUSY;
          cnt_nxt   = LAT_M1;
          op_wr_nxt = mem_write;
          idx_nxt   = mem_address[IDX_W-1:0];
          wdata_nxt = mem_WRITE_DATA;
          busy_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          if (op_wr) do_write = 1'b1;
          else       rdata_nxt = array[idx];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The array has no reset; a write aborted by reset never reaches it.
  always_ff @(posedge CLOCK) begin
    if (do_write) array[idx] <= wdata;
  end

endmodule
